// File: rtl/imm_extend_pipe.sv
// Immediate extender with optional prefix: one registered stage, result one cycle after accept.
// Valid/ready handshake; In_Ready drops while an unconsumed result is held.
module imm_extend_pipe #(
    parameter int INSTR_W = 38,
    parameter int DATA_W  = 24,
    parameter int IMM0_W  = 10,
    parameter int IMM1_W  = 16,
    parameter int IMM2_W  = 2,
    parameter int PFX_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [INSTR_W-1:0] In,
    input  logic [2:0]         ImmSrc,
    input  logic               Flush,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [DATA_W-1:0]  Imm_Ext,
    output logic               Imm_Err,
    output logic               Pfx_Pending
);

    typedef enum logic {IDLE, PFX} state_t;

    // Fields at least DATA_W wide get an all-ones mask, i.e. plain truncation.
    localparam logic [DATA_W-1:0] MASK0 =
        (IMM0_W >= DATA_W) ? '1 : DATA_W'((64'd1 << IMM0_W) - 64'd1);
    localparam logic [DATA_W-1:0] MASK1 =
        (IMM1_W >= DATA_W) ? '1 : DATA_W'((64'd1 << IMM1_W) - 64'd1);
    localparam logic [DATA_W-1:0] MASK2 =
        (IMM2_W >= DATA_W) ? '1 : DATA_W'((64'd1 << IMM2_W) - 64'd1);

    state_t             state_q, state_d;
    logic [PFX_W-1:0]   pfx_q, pfx_d;
    logic               out_vld_q, out_vld_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic               err_q, err_d;

    logic               accept;
    logic [DATA_W-1:0]  in_lo;
    logic [DATA_W-1:0]  fmt_imm;
    logic               unused_in;

    assign unused_in = ^In;
    assign in_lo     = DATA_W'(In);

    assign In_Ready    = !out_vld_q || Out_Ready;
    assign accept      = In_Valid && In_Ready && !Flush;
    assign Out_Valid   = out_vld_q;
    assign Imm_Ext     = imm_q;
    assign Imm_Err     = err_q;
    assign Pfx_Pending = (state_q == PFX);

    always_comb begin
        fmt_imm = '0;
        case (ImmSrc)
            3'b000: fmt_imm = In[IMM0_W-1] ? (in_lo | ~MASK0) : (in_lo & MASK0);
            3'b001: fmt_imm = In[IMM1_W-1] ? (in_lo | ~MASK1) : (in_lo & MASK1);
            3'b010: fmt_imm = In[IMM2_W-1] ? (in_lo | ~MASK2) : (in_lo & MASK2);
            3'b011: fmt_imm = in_lo & MASK1;
            default: fmt_imm = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pfx_d     = pfx_q;
        out_vld_d = out_vld_q && !Out_Ready;
        imm_d     = imm_q;
        err_d     = err_q;
        if (Flush) begin
            // Flush wins over a same-cycle accept; the result data is left as is.
            out_vld_d = 1'b0;
            state_d   = IDLE;
            pfx_d     = '0;
        end else if (accept) begin
            case (ImmSrc)
                3'b100: begin
                    pfx_d   = In[PFX_W-1:0];
                    state_d = PFX;
                end
                3'b000, 3'b001, 3'b010, 3'b011: begin
                    out_vld_d = 1'b1;
                    err_d     = 1'b0;
                    imm_d     = (state_q == PFX) ? {pfx_q, In[DATA_W-PFX_W-1:0]} : fmt_imm;
                    state_d   = IDLE;
                end
                default: begin
                    out_vld_d = 1'b1;
                    err_d     = 1'b1;
                    imm_d     = '0;
                    state_d   = IDLE;
                    pfx_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pfx_q     <= '0;
            out_vld_q <= 1'b0;
            imm_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pfx_q     <= pfx_d;
            out_vld_q <= out_vld_d;
            imm_q     <= imm_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: vector table plus hand-written multi-cycle sequences.
module tb_imm_extend_pipe;

    localparam int INSTR_W = 38;
    localparam int DATA_W  = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               In_Valid;
    logic               In_Ready;
    logic [INSTR_W-1:0] In;
    logic [2:0]         ImmSrc;
    logic               Flush;
    logic               Out_Valid;
    logic               Out_Ready;
    logic [DATA_W-1:0]  Imm_Ext;
    logic               Imm_Err;
    logic               Pfx_Pending;

    int n_cmp = 0;
    int n_bad = 0;

    imm_extend_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .In          (In),
        .ImmSrc      (ImmSrc),
        .Flush       (Flush),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Imm_Ext     (Imm_Ext),
        .Imm_Err     (Imm_Err),
        .Pfx_Pending (Pfx_Pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]         src;
        logic [INSTR_W-1:0] in;
        logic [DATA_W-1:0]  imm;
        logic               err;
    } vec_t;

    vec_t tbl[10];
    vec_t strm[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one instruction for one cycle; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] src, input logic [INSTR_W-1:0] val);
        @(negedge clk);
        In_Valid = 1'b1;
        ImmSrc   = src;
        In       = val;
        @(negedge clk);
        In_Valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'b000, 38'h0000003FF, 24'hFFFFFF, 1'b0};
        tbl[1] = '{3'b001, 38'h000008000, 24'hFF8000, 1'b0};
        tbl[2] = '{3'b011, 38'h000008000, 24'h008000, 1'b0};
        tbl[3] = '{3'b010, 38'h000000001, 24'h000001, 1'b0};
        tbl[4] = '{3'b010, 38'h000000002, 24'hFFFFFE, 1'b0};
        tbl[5] = '{3'b000, 38'h000000200, 24'hFFFE00, 1'b0};
        tbl[6] = '{3'b001, 38'h000007FFF, 24'h007FFF, 1'b0};
        tbl[7] = '{3'b011, 38'h00000FFFF, 24'h00FFFF, 1'b0};
        tbl[8] = '{3'b110, 38'h000001234, 24'h000000, 1'b1};
        tbl[9] = '{3'b101, 38'h00000FFFF, 24'h000000, 1'b1};

        strm[0] = '{3'b011, 38'h0000000A5, 24'h0000A5, 1'b0};
        strm[1] = '{3'b001, 38'h00000FFFE, 24'hFFFFFE, 1'b0};
        strm[2] = '{3'b000, 38'h000000155, 24'h000155, 1'b0};
        strm[3] = '{3'b010, 38'h000000001, 24'h000001, 1'b0};

        rst = 1'b1; In_Valid = 1'b0; In = '0; ImmSrc = 3'b000; Flush = 1'b0; Out_Ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("rst_imm", 64'(Imm_Ext), 64'd0);
        chk("rst_err", 64'(Imm_Err), 64'd0);
        chk("rst_pfx_pending", 64'(Pfx_Pending), 64'd0);
        chk("rst_in_ready", 64'(In_Ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].src, tbl[i].in);
            chk($sformatf("tbl%0d_valid", i), 64'(Out_Valid), 64'd1);
            chk($sformatf("tbl%0d_imm", i), 64'(Imm_Ext), 64'(tbl[i].imm));
            chk($sformatf("tbl%0d_err", i), 64'(Imm_Err), 64'(tbl[i].err));
        end

        // Prefix then short immediate: upper In bits above the slice must be ignored.
        @(negedge clk);
        In_Valid = 1'b1; ImmSrc = 3'b100; In = 38'h00000ABCD;
        @(negedge clk);
        chk("pfx_pending_between", 64'(Pfx_Pending), 64'd1);
        chk("pfx_no_output", 64'(Out_Valid), 64'd0);
        ImmSrc = 3'b000; In = 38'h00000FF12;
        @(negedge clk);
        In_Valid = 1'b0;
        chk("pfx_valid", 64'(Out_Valid), 64'd1);
        chk("pfx_imm", 64'(Imm_Ext), 64'hABCD12);
        chk("pfx_pending_after", 64'(Pfx_Pending), 64'd0);
        @(negedge clk);
        chk("pfx_single_pulse", 64'(Out_Valid), 64'd0);

        // Stall: held result with a competing request that must not be accepted.
        Out_Ready = 1'b0;
        send(3'b001, 38'h000001234);
        In_Valid = 1'b1; ImmSrc = 3'b000; In = 38'h0000003FF;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_in_ready", c), 64'(In_Ready), 64'd0);
            chk($sformatf("stall%0d_valid", c), 64'(Out_Valid), 64'd1);
            chk($sformatf("stall%0d_imm", c), 64'(Imm_Ext), 64'h001234);
            @(negedge clk);
        end
        Out_Ready = 1'b1;
        @(negedge clk);
        In_Valid = 1'b0;
        chk("unstall_valid", 64'(Out_Valid), 64'd1);
        chk("unstall_imm", 64'(Imm_Ext), 64'hFFFFFF);
        @(negedge clk);

        // Back-to-back stream of four accepts.
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                chk($sformatf("strm%0d_valid", i - 1), 64'(Out_Valid), 64'd1);
                chk($sformatf("strm%0d_imm", i - 1), 64'(Imm_Ext), 64'(strm[i - 1].imm));
            end
            if (i < 4) begin
                In_Valid = 1'b1; ImmSrc = strm[i].src; In = strm[i].in;
            end else begin
                In_Valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("strm_drained", 64'(Out_Valid), 64'd0);

        // Prefix followed by an illegal format.
        send(3'b100, 38'h000005555);
        send(3'b111, 38'h000000012);
        chk("pfx_ill_valid", 64'(Out_Valid), 64'd1);
        chk("pfx_ill_imm", 64'(Imm_Ext), 64'd0);
        chk("pfx_ill_err", 64'(Imm_Err), 64'd1);
        chk("pfx_ill_pending", 64'(Pfx_Pending), 64'd0);
        send(3'b000, 38'h000000005);
        chk("post_ill_imm", 64'(Imm_Ext), 64'h000005);
        chk("post_ill_err", 64'(Imm_Err), 64'd0);

        // Flush in PFX with a simultaneous request: dropped, back to IDLE, data untouched.
        send(3'b100, 38'h000007777);
        @(negedge clk);
        Flush = 1'b1; In_Valid = 1'b1; ImmSrc = 3'b001; In = 38'h000008000;
        @(negedge clk);
        Flush = 1'b0; In_Valid = 1'b0;
        chk("flush_no_output", 64'(Out_Valid), 64'd0);
        chk("flush_idle", 64'(Pfx_Pending), 64'd0);
        chk("flush_imm_kept", 64'(Imm_Ext), 64'h000005);
        send(3'b001, 38'h000000001);
        chk("post_flush_imm", 64'(Imm_Ext), 64'h000001);

        // Flush drops a stalled result.
        Out_Ready = 1'b0;
        send(3'b000, 38'h000000003);
        chk("stalled_before_flush", 64'(Out_Valid), 64'd1);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        chk("flush_clears_valid", 64'(Out_Valid), 64'd0);

        // Asynchronous reset mid-cycle with a stalled result.
        send(3'b001, 38'h000000042);
        chk("pre_rst_valid", 64'(Out_Valid), 64'd1);
        rst = 1'b1;
        #2;
        chk("arst_valid", 64'(Out_Valid), 64'd0);
        chk("arst_imm", 64'(Imm_Ext), 64'd0);
        chk("arst_in_ready", 64'(In_Ready), 64'd1);
        #1 rst = 1'b0;
        Out_Ready = 1'b1;

        // Asynchronous reset mid-cycle while in PFX: prefix must be lost.
        send(3'b100, 38'h00000BEEF);
        chk("pre_rst_pfx", 64'(Pfx_Pending), 64'd1);
        rst = 1'b1;
        #2;
        chk("arst_pfx_pending", 64'(Pfx_Pending), 64'd0);
        #1 rst = 1'b0;
        send(3'b000, 38'h000000012);
        chk("post_rst_valid", 64'(Out_Valid), 64'd1);
        chk("post_rst_prefix_lost", 64'(Imm_Ext), 64'h000012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have a parameter INSTR_W, default 38, giving the instruction input width.
REQ-002 The block SHALL have a parameter DATA_W, default 24, giving the extended immediate width.
REQ-003 The block SHALL have parameters IMM0_W = 10, IMM1_W = 16 and IMM2_W = 2, giving the short, long and tiny immediate field widths at In[W-1:0].
REQ-004 The block SHALL have a parameter PFX_W, default 16, giving the prefix width, with constraint PFX_W < DATA_W.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port In_Valid, input, 1 bit: the upstream instruction is valid.
REQ-008 The block SHALL have port In_Ready, output, 1 bit: the block can accept an instruction.
REQ-009 The block SHALL have port In, input, INSTR_W bits: the instruction word.
REQ-010 The block SHALL have port ImmSrc, input, 3 bits: the immediate format select.
REQ-011 The block SHALL have port Flush, input, 1 bit: synchronous pipeline flush.
REQ-012 The block SHALL have port Out_Valid, output, 1 bit: Imm_Ext is valid.
REQ-013 The block SHALL have port Out_Ready, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port Imm_Ext, output, DATA_W bits: the extended immediate.
REQ-015 The block SHALL have port Imm_Err, output, 1 bit: set when the result came from an illegal ImmSrc.
REQ-016 The block SHALL have port Pfx_Pending, output, 1 bit: a prefix is held.

Function
REQ-017 An input is accepted when In_Valid && In_Ready; In_Ready SHALL equal !Out_Valid || Out_Ready.
REQ-018 Non-prefixed formats, each registered to Imm_Ext one cycle after accept:
- ImmSrc 000: sign-extend In[IMM0_W-1:0].
- ImmSrc 001: sign-extend In[IMM1_W-1:0].
- ImmSrc 010: sign-extend In[IMM2_W-1:0].
- ImmSrc 011: zero-extend In[IMM1_W-1:0].
REQ-019 ImmSrc 100 (prefix capture) SHALL store In[PFX_W-1:0] in the prefix register, enter state PFX, and produce no output (Out_Valid unchanged by this accept).
REQ-020 ImmSrc 101, 110 and 111 SHALL produce Imm_Ext = 0 with Imm_Err = 1; all other results SHALL have Imm_Err = 0.
REQ-021 The state machine SHALL have states IDLE and PFX.
- IDLE -> PFX on an accepted 100.
- PFX -> IDLE on an accepted 000–011, 101–111, or on Flush.
REQ-022 In PFX, an accepted 000–011 SHALL output {prefix, In[DATA_W-PFX_W-1:0]}, ignoring the format's own extension.
REQ-023 In PFX, an accepted 101–111 SHALL output 0 with Imm_Err = 1 and discard the prefix.
REQ-024 In PFX, an accepted 100 SHALL overwrite the prefix and remain in PFX.
REQ-025 Pfx_Pending SHALL be 1 exactly when in state PFX.
REQ-026 The output register SHALL hold Imm_Ext and Imm_Err stable while Out_Valid && !Out_Ready.
REQ-027 A simultaneous output handoff and new accept SHALL give back-to-back throughput of 1 result per cycle.
REQ-028 Flush SHALL clear Out_Valid, return to IDLE and clear the prefix on the next edge.
REQ-029 Flush SHALL take priority over a simultaneous accept, which is dropped.
REQ-030 Imm_Ext SHALL be unchanged by Flush.
REQ-031 Sign extension SHALL replicate bit W-1 across bits DATA_W-1:W.
REQ-032 If a field width is greater than or equal to DATA_W, the field SHALL be truncated to its low DATA_W bits.

Reset
REQ-033 While rst = 1: Out_Valid = 0, Imm_Ext = 0, Imm_Err = 0, state = IDLE, prefix = 0, Pfx_Pending = 0, and In_Ready = 1 (combinational from Out_Valid).
REQ-034 Reset asserted mid-operation, including in PFX or with a stalled output, SHALL discard all held data immediately and asynchronously.
REQ-035 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-036 The bench SHALL check: 000 with In[9:0] = 10'h3FF -> Imm_Ext = 24'hFFFFFF one cycle later; 001 with In[15:0] = 16'h8000 -> 24'hFF8000; 011 with the same input -> 24'h008000; 010 with In[1:0] = 2'b01 -> 24'h000001.
REQ-037 The bench SHALL check: 100 with In[15:0] = 16'hABCD, then 000 with In[7:0] = 8'h12 -> a single Out_Valid pulse with Imm_Ext = 24'hABCD12, and Pfx_Pending 1 for exactly one cycle between the two accepts.
REQ-038 The bench SHALL check: Out_Ready = 0 for 3 cycles with a result held -> In_Ready = 0 and Imm_Ext stable; a stream of 4 accepts with Out_Ready = 1 -> 4 results on consecutive cycles.
REQ-039 The bench SHALL check: ImmSrc 110 -> Imm_Ext = 0 with Imm_Err = 1; a prefix followed by 111 -> 0 with Imm_Err = 1 and Pfx_Pending cleared.
REQ-040 The bench SHALL check: Flush asserted in PFX together with In_Valid for 001 -> no output, state IDLE; a following 001 with 16'h0001 -> 24'h000001.
REQ-041 The bench SHALL check: rst pulsed mid-cycle while Out_Valid = 1 and in PFX -> outputs zero before the next edge and prefix lost.
